// File: rtl/packet_scheduler.sv
// packet_scheduler: chooses one data-island packet per slot from the audio FIFO, ACR, InfoFrames or null,
// and tracks the audio frame counter over emitted audio samples.
module packet_scheduler #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int AUDIO_LAYOUT    = 0,
    parameter int FIFO_DEPTH      = 8,
    parameter int NUM_INFOFRAMES  = 2,
    parameter int ACR_MAX_DEFER   = 4,
    localparam int CH = AUDIO_LAYOUT != 0 ? 8 : 2,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    input  logic                          packet_enable,
    input  logic [4:0]                    packet_pixel_counter,
    input  logic                          video_field_end,
    input  logic                          audio_valid,
    input  logic [CH*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    input  logic                          acr_request,
    input  logic [NUM_INFOFRAMES*8-1:0]   infoframe_type,
    output logic [7:0]                    packet_type,
    output logic [191:0]                  audio_payload,
    output logic [3:0]                    sample_present,
    output logic [7:0]                    frame_counter,
    output logic [LW-1:0]                 fifo_level,
    output logic                          fifo_overflow
);
    localparam int W   = CH * AUDIO_BIT_WIDTH;
    localparam int NPK = AUDIO_LAYOUT != 0 ? 1 : 4;
    localparam int DW  = $clog2(ACR_MAX_DEFER + 1);

    logic [W-1:0]              r_mem [FIFO_DEPTH];
    logic [AW-1:0]             r_wr, r_rd;
    logic [DW-1:0]             r_defer;
    logic                      r_acr_pend;
    logic [NUM_INFOFRAMES-1:0] r_if_mask;
    logic                      w_force, w_aud, w_acr, w_ifs, w_room, w_acc;
    logic [2:0]                w_pop;
    logic [3:0]                w_present;
    logic [7:0]                w_if_type;
    logic [NUM_INFOFRAMES-1:0] w_if_clr;
    logic [W-1:0]              w_ent;
    logic [191:0]              w_payload;
    logic [8:0]                w_fc_sum;

    always_comb begin
        w_force = r_acr_pend && (r_defer == DW'(ACR_MAX_DEFER));
        w_aud = !w_force && (fifo_level != '0);
        w_acr = w_force || (!w_aud && r_acr_pend);
        w_ifs = !w_aud && !w_acr && (|r_if_mask);
        w_pop = !(packet_enable && w_aud) ? 3'd0 : AUDIO_LAYOUT != 0 ? 3'd1 :
                fifo_level >= LW'(4) ? 3'd4 : fifo_level[2:0];
        w_present = AUDIO_LAYOUT != 0 ? {4{w_pop != 3'd0}} : 4'((5'd1 << w_pop) - 5'd1);
        // room is judged after this cycle's pop so a full FIFO can still accept while draining
        w_room = (fifo_level - LW'(w_pop)) < LW'(FIFO_DEPTH);
        w_acc = audio_valid && w_room;
        w_if_type = 8'h00;
        w_if_clr = '0;
        for (int i = NUM_INFOFRAMES - 1; i >= 0; i--)
            if (r_if_mask[i]) begin
                w_if_type = infoframe_type[i*8 +: 8];
                w_if_clr = NUM_INFOFRAMES'(1) << i;
            end
        w_ent = '0;
        w_payload = '0;
        for (int k = 0; k < NPK; k++) begin
            w_ent = r_mem[r_rd + AW'(k)];
            for (int c = 0; c < CH; c++)
                if (k < int'(w_pop))
                    w_payload[(k*CH+c)*24 +: 24] = 24'(w_ent[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
        end
        w_fc_sum = {1'b0, frame_counter} + (AUDIO_LAYOUT != 0 ? 9'd1 : 9'($countones(sample_present)));
    end

    always_ff @(posedge clk_pixel)
        if (w_acc) r_mem[r_wr] <= audio_sample_word;

    always_ff @(posedge clk_pixel or posedge reset)
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_defer <= '0;
            r_acr_pend <= 1'b0;
            r_if_mask <= '1;
            packet_type <= 8'h00;
            audio_payload <= '0;
            sample_present <= 4'h0;
            frame_counter <= 8'h00;
            fifo_level <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            r_wr <= r_wr + AW'(w_acc);
            r_rd <= r_rd + AW'(w_pop);
            fifo_level <= fifo_level + LW'(w_acc) - LW'(w_pop);
            fifo_overflow <= fifo_overflow || (audio_valid && !w_room);
            r_acr_pend <= acr_request || (r_acr_pend && !(packet_enable && w_acr));
            r_if_mask <= video_field_end ? '1 : r_if_mask & ~((packet_enable && w_ifs) ? w_if_clr : '0);
            if (packet_enable) begin
                packet_type <= w_acr ? 8'h01 : w_aud ? 8'h02 : w_ifs ? w_if_type : 8'h00;
                audio_payload <= w_payload;
                sample_present <= w_present;
                r_defer <= w_acr ? '0 :
                           (r_acr_pend && r_defer != DW'(ACR_MAX_DEFER)) ? r_defer + 1'b1 : r_defer;
            end
            if (packet_pixel_counter == 5'd31 && packet_type == 8'h02)
                frame_counter <= w_fc_sum >= 9'd192 ? 8'(w_fc_sum - 9'd192) : w_fc_sum[7:0];
        end
endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: directed checks of packet_scheduler in 2-channel and 8-channel layouts.
module tb_packet_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, fe = 1'b0, valid = 1'b0, acr = 1'b0;
    logic [4:0] pix = 5'd0;
    logic [31:0] word = '0;
    logic [15:0] ift = 16'h8482;
    logic [7:0] a_type, a_fc;
    logic [191:0] a_payload;
    logic [3:0] a_present, a_level;
    logic a_ovf;
    logic b_en = 1'b0, b_valid = 1'b0;
    logic [4:0] b_pix = 5'd0;
    logic [127:0] b_word = '0;
    logic [7:0] b_type, b_fc;
    logic [191:0] b_payload, b_exp;
    logic [3:0] b_present, b_level;
    logic b_ovf;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    packet_scheduler dut_a (
        .clk_pixel(clk), .reset(rst), .packet_enable(en), .packet_pixel_counter(pix),
        .video_field_end(fe), .audio_valid(valid), .audio_sample_word(word), .acr_request(acr),
        .infoframe_type(ift), .packet_type(a_type), .audio_payload(a_payload),
        .sample_present(a_present), .frame_counter(a_fc), .fifo_level(a_level), .fifo_overflow(a_ovf)
    );

    packet_scheduler #(.AUDIO_LAYOUT(1)) dut_b (
        .clk_pixel(clk), .reset(rst), .packet_enable(b_en), .packet_pixel_counter(b_pix),
        .video_field_end(1'b0), .audio_valid(b_valid), .audio_sample_word(b_word), .acr_request(1'b0),
        .infoframe_type(ift), .packet_type(b_type), .audio_payload(b_payload),
        .sample_present(b_present), .frame_counter(b_fc), .fifo_level(b_level), .fifo_overflow(b_ovf)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        valid = 1'b1;
        word = w;
        step();
        valid = 1'b0;
    endtask

    task automatic slot(input string tag, input logic [7:0] t);
        en = 1'b1;
        step();
        en = 1'b0;
        check(tag, a_type, t);
    endtask

    task automatic pix31();
        pix = 5'd31;
        step();
        pix = 5'd0;
    endtask

    task automatic b_cycle();
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        b_en = 1'b1;
        step();
        b_en = 1'b0;
        b_pix = 5'd31;
        step();
        b_pix = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("rst_type", a_type, 8'h00);
        check("rst_payload", a_payload, '0);
        check("rst_present", a_present, 4'h0);
        check("rst_fc", a_fc, 8'd0);
        check("rst_level", a_level, 4'd0);
        check("rst_ovf", a_ovf, 1'b0);
        rst = 1'b0;

        slot("if_first", 8'h82);
        slot("if_second", 8'h84);
        slot("if_done", 8'h00);
        fe = 1'b1; step(); fe = 1'b0;
        slot("if_field2_a", 8'h82);
        fe = 1'b1;
        slot("if_field2_b", 8'h84);
        fe = 1'b0;
        slot("if_reload_a", 8'h82);
        slot("if_reload_b", 8'h84);
        slot("if_reload_done", 8'h00);

        push(32'hA001_B001);
        push(32'hA002_B002);
        push(32'hA003_B003);
        check("aud3_level_pre", a_level, 4'd3);
        slot("aud3_type", 8'h02);
        check("aud3_present", a_present, 4'b0111);
        check("aud3_level", a_level, 4'd0);
        check("aud3_payload", a_payload,
              {48'h0, 24'h00A003, 24'h00B003, 24'h00A002, 24'h00B002, 24'h00A001, 24'h00B001});
        slot("aud3_then_null", 8'h00);
        check("null_payload", a_payload, '0);
        check("null_present", a_present, 4'h0);

        for (int i = 0; i < 10; i++) push({16'(16'hC000 + i), 16'(16'hD000 + i)});
        check("full_level", a_level, 4'd8);
        check("full_ovf", a_ovf, 1'b1);
        valid = 1'b1;
        word = 32'hE000_F000;
        slot("full_pushpop_type", 8'h02);
        valid = 1'b0;
        check("full_pushpop_level", a_level, 4'd5);
        check("full_pushpop_present", a_present, 4'b1111);
        check("full_pushpop_payload", a_payload,
              {24'h00C003, 24'h00D003, 24'h00C002, 24'h00D002, 24'h00C001, 24'h00D001, 24'h00C000, 24'h00D000});
        slot("drain4_type", 8'h02);
        check("drain4_level", a_level, 4'd1);
        check("drain4_payload", a_payload,
              {24'h00C007, 24'h00D007, 24'h00C006, 24'h00D006, 24'h00C005, 24'h00D005, 24'h00C004, 24'h00D004});
        slot("drain1_type", 8'h02);
        check("drain1_present", a_present, 4'b0001);
        check("drain1_level", a_level, 4'd0);
        check("drain1_payload", a_payload, {144'h0, 24'h00E000, 24'h00F000});
        check("ovf_sticky", a_ovf, 1'b1);

        do_reset();
        check("ovf_cleared", a_ovf, 1'b0);
        acr = 1'b1; step(); acr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_1000 + 32'(i));
            slot($sformatf("acr_defer_%0d", i), 8'h02);
        end
        push(32'h0000_2000);
        slot("acr_forced", 8'h01);
        check("acr_forced_level", a_level, 4'd1);
        acr = 1'b1; step(); acr = 1'b0;
        push(32'h0000_3000);
        slot("acr_defer_cleared", 8'h02);
        check("acr_pop2_present", a_present, 4'b0011);
        slot("acr_no_audio", 8'h01);
        slot("acr_then_if", 8'h82);
        acr = 1'b1; step();
        slot("acr_coincide", 8'h01);
        acr = 1'b0;
        slot("acr_kept", 8'h01);
        slot("acr_kept_then_if", 8'h84);

        do_reset();
        acr = 1'b1; step(); acr = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h0000_4000 + 32'(i));
        slot("mid_audio", 8'h02);
        check("mid_level_pre", a_level, 4'd1);
        pix = 5'd31;
        rst = 1'b1;
        #1;
        check("mid_type", a_type, 8'h00);
        check("mid_payload", a_payload, '0);
        check("mid_present", a_present, 4'h0);
        check("mid_level", a_level, 4'd0);
        check("mid_fc", a_fc, 8'd0);
        step();
        rst = 1'b0;
        pix = 5'd0;
        check("mid_fc_after", a_fc, 8'd0);
        slot("mid_first_slot", 8'h82);

        for (int n = 0; n < 47; n++) begin
            for (int i = 0; i < 4; i++) push(32'(n * 4 + i));
            en = 1'b1; step(); en = 1'b0;
            pix31();
        end
        check("fc_188", a_fc, 8'd188);
        push(32'h1); push(32'h2);
        slot("fc_pkt2", 8'h02);
        pix31();
        check("fc_190", a_fc, 8'd190);
        for (int i = 0; i < 4; i++) push(32'(i));
        slot("fc_pkt4", 8'h02);
        pix31();
        check("fc_wrap", a_fc, 8'd2);
        slot("fc_non_audio", 8'h84);
        pix31();
        check("fc_hold", a_fc, 8'd2);

        do_reset();
        b_exp = '0;
        for (int j = 0; j < 8; j++) begin
            b_word[j*16 +: 16] = 16'(16'h1100 + j);
            b_exp[j*24 +: 24] = 24'(24'h001100 + j);
        end
        b_valid = 1'b1; step(); step(); b_valid = 1'b0;
        b_en = 1'b1; step(); b_en = 1'b0;
        check("b_type", b_type, 8'h02);
        check("b_present", b_present, 4'b1111);
        check("b_level", b_level, 4'd1);
        check("b_payload", b_payload, b_exp);
        b_pix = 5'd31; step(); b_pix = 5'd0;
        check("b_fc_1", b_fc, 8'd1);
        b_en = 1'b1; step(); b_en = 1'b0;
        b_pix = 5'd31; step(); b_pix = 5'd0;
        check("b_fc_2", b_fc, 8'd2);
        for (int n = 0; n < 189; n++) b_cycle();
        check("b_fc_191", b_fc, 8'd191);
        b_cycle();
        check("b_fc_wrap", b_fc, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
